// File: rtl/neg_pkg.sv
// Shared types and helpers for the digit-serial negate / absolute-value unit.
// ABS mode is built only when NEG_ABS_EN is defined.
package neg_pkg;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_NEG  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   localparam int unsigned MAX_W = 64;

   // Callers truncate to their own operand width.
   function automatic logic [MAX_W-1:0] most_neg(input int unsigned w);
      logic [MAX_W-1:0] one;
      one = {{(MAX_W-1){1'b0}}, 1'b1};
      return one << (w - 1);
   endfunction

endpackage

// File: rtl/neg_chunk.sv
// One CHUNK-bit slice: conditional invert, then add the incoming carry
// through a propagate/generate carry-lookahead network.
module neg_chunk
   import neg_pkg::*;
#(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic             inv,
   input  logic             c_in,
   output logic [CHUNK-1:0] s,
   output logic             c_out
);

   logic [CHUNK-1:0] x;
   logic [CHUNK-1:0] p;
   logic [CHUNK-1:0] g;
   logic [CHUNK:0]   c;

   // The second addend is zero, so the half adders never generate.
   always_comb begin
      x = a ^ {CHUNK{inv}};
      p = x;
      g = '0;
   end

   always_comb begin
      c    = '0;
      c[0] = c_in;
      for (int i = 0; i < CHUNK; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   assign s     = p ^ c[CHUNK-1:0];
   assign c_out = c[CHUNK];

endmodule

// File: rtl/neg_serial.sv
// Digit-serial two's-complement negate / absolute-value unit, CHUNK bits per cycle.
// Define NEG_ABS_EN to build ABS mode; otherwise ABS behaves as PASS.
module neg_serial
   import neg_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
   output logic             out_c,
   output logic             out_ovf
);

   generate
      if (CHUNK < 1) begin : g_chk_chunk
         $error("neg_serial: CHUNK must be at least 1");
      end else if ((WIDTH % CHUNK) != 0) begin : g_chk_width
         $error("neg_serial: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0]    K_LAST = KW'(N - 1);
   localparam logic [WIDTH-1:0] MNEG   = WIDTH'(most_neg(WIDTH));

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic             inv_q, inv_d;
   logic             ovf_q, ovf_d;

   logic             inv_sel;
   logic             accept;
   logic             last;
   logic [CHUNK-1:0] a_k;
   logic [CHUNK-1:0] s_k;
   logic             c_next;

   assign accept = (state_q == ST_IDLE) & in_valid;
   assign last   = (k_q == K_LAST);
   assign a_k    = a_q[k_q*CHUNK +: CHUNK];

   always_comb begin
      inv_sel = 1'b0;
      unique case (mode_e'(in_mode))
         MODE_NEG: inv_sel = 1'b1;
`ifdef NEG_ABS_EN
         MODE_ABS: inv_sel = in_a[WIDTH-1];
`else
         MODE_ABS: inv_sel = 1'b0;
`endif
         MODE_PASS,
         MODE_RSVD: inv_sel = 1'b0;
         default:   inv_sel = 1'b0;
      endcase
   end

   neg_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a     (a_k),
      .inv   (inv_q),
      .c_in  (carry_q),
      .s     (s_k),
      .c_out (c_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (in_valid)  state_d = ST_RUN;
         ST_RUN:  if (last)      state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         res_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         inv_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         res_q   <= res_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         inv_q   <= inv_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      a_d     = a_q;
      res_d   = res_q;
      k_d     = k_q;
      carry_d = carry_q;
      inv_d   = inv_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = in_a;
         inv_d   = inv_sel;
         carry_d = inv_sel;
         ovf_d   = inv_sel & (in_a == MNEG);
         k_d     = '0;
      end else if (state_q == ST_RUN) begin
         res_d[k_q*CHUNK +: CHUNK] = s_k;
         carry_d = c_next;
         k_d     = last ? '0 : k_q + 1'b1;
      end
   end

   // After the last chunk the carry register holds the MSB carry-out.
   assign out_s   = res_q;
   assign out_c   = carry_q;
   assign out_ovf = ovf_q;

endmodule

// File: tb/tb_neg_serial.sv
// Directed self-checking bench for neg_serial (WIDTH=16, CHUNK=4).
module tb_neg_serial;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [1:0]  in_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_s;
   logic        out_c;
   logic        out_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   neg_serial #(
      .WIDTH (16),
      .CHUNK (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_s     (out_s),
      .out_c     (out_c),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offer one operand, wait for the result and compare it.
   task automatic run_op(input string tag, input logic [1:0] mode,
                         input logic [15:0] a, input logic [15:0] exp_s,
                         input logic exp_c, input logic exp_ovf,
                         input bit chk_lat);
      int cnt;
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(posedge clk); #1; cnt++;
      end
      check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      in_a     = a;
      in_mode  = mode;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 20) begin
         @(posedge clk); #1; cnt++;
      end
      if (chk_lat) check({tag, "_lat"}, cnt, 32'd4);
      check({tag, "_s"},   {16'd0, out_s},     {16'd0, exp_s});
      check({tag, "_c"},   {31'd0, out_c},     {31'd0, exp_c});
      check({tag, "_ovf"}, {31'd0, out_ovf},   {31'd0, exp_ovf});
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int cnt;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_mode   = 2'b00;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_s",     {16'd0, out_s},     32'd0);
      check("rst_out_c",     {31'd0, out_c},     32'd0);
      check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("neg1",    2'b01, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      run_op("neg0",    2'b01, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
      run_op("neg100",  2'b01, 16'h0100, 16'hFF00, 1'b0, 1'b0, 1'b0);
      run_op("negmin",  2'b01, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
      run_op("passmin", 2'b00, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
      run_op("rsvd",    2'b11, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
`ifdef NEG_ABS_EN
      run_op("absneg",  2'b10, 16'hFF9C, 16'h0064, 1'b0, 1'b0, 1'b0);
      run_op("absmin",  2'b10, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0);
`else
      run_op("absneg",  2'b10, 16'hFF9C, 16'hFF9C, 1'b0, 1'b0, 1'b0);
      run_op("absmin",  2'b10, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
`endif
      run_op("abspos",  2'b10, 16'h0064, 16'h0064, 1'b0, 1'b0, 1'b0);

      // Backpressure: hold the result while stray operands are offered.
      out_ready = 1'b0;
      run_op("bp", 2'b01, 16'h00FF, 16'hFF01, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = 16'h5555 + 16'(i);
         in_mode  = 2'b01;
         @(posedge clk); #1;
         in_valid = 1'b0;
         check("bp_hold_s",   {16'd0, out_s},     32'h0000FF01);
         check("bp_hold_c",   {31'd0, out_c},     32'd0);
         check("bp_hold_ovf", {31'd0, out_ovf},   32'd0);
         check("bp_in_ready", {31'd0, in_ready},  32'd0);
         check("bp_valid",    {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_rel_ready", {31'd0, in_ready},  32'd1);
      check("bp_rel_valid", {31'd0, out_valid}, 32'd0);
      run_op("bp2", 2'b01, 16'h0002, 16'hFFFE, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a run.
      in_a     = 16'hFFFF;
      in_mode  = 2'b01;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_ready", {31'd0, in_ready},  32'd1);
      check("mrst_s",     {16'd0, out_s},     32'd0);
      check("mrst_c",     {31'd0, out_c},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      @(posedge clk); #1;
      check("mrst_idle", {31'd0, out_valid}, 32'd0);
      run_op("post_rst", 2'b01, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
